store_issue: RTL and testbench

- Write-side counterpart of the load-result extraction in write-back. It accepts committed store requests from the MEM stage.
- Aligns data and generates byte strobes for each store, then holds the stores in a small FIFO store buffer.
- Drains the buffer, one transaction at a time, onto the SRAM-like data bus using a req/addr_ok/data_ok handshake.
- Flags misaligned stores and load/store address hazards.

---
 rtl/store_issue_pkg.sv | 35 +++
 rtl/store_buffer_fifo.sv | 73 +++++++
 rtl/store_issue.sv | 173 +++++++++++++++++
 tb/tb_store_issue.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_issue_pkg.sv
// Shared constants for store_issue: bus widths, size codes,
// drain FSM states and the store-buffer entry layout.
package store_issue_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;
    localparam int WORD_W = ADDR_W - 2;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } sb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        size;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } sb_entry_t;

    function automatic logic word_hit(
        input logic              valid,
        input logic [WORD_W-1:0] a,
        input logic [WORD_W-1:0] b
    );
        return valid & (a == b);
    endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular store buffer; exposes every slot's word address and
// occupancy so the issue stage can check load hazards.
module store_buffer_fifo
    import store_issue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_i,
    input  sb_entry_t                     push_entry_i,
    input  logic                          pop_i,
    output sb_entry_t                     head_o,
    output logic [CNT_W-1:0]              count_o,
    output logic [DEPTH-1:0]              ent_valid_o,
    output logic [DEPTH-1:0][WORD_W-1:0]  ent_word_o
);

    localparam int PTR_W = $clog2(DEPTH);

    sb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] head_d;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W-1:0] tail_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_i) tail_d = tail_q + 1'b1;
        if (pop_i)  head_d = head_q + 1'b1;
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[tail_q] <= push_entry_i;
    end

    always_comb begin
        logic [PTR_W-1:0] off;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off            = PTR_W'(i) - head_q;
            ent_valid_o[i] = CNT_W'(off) < count_q;
            ent_word_o[i]  = mem_q[i].addr[ADDR_W-1:2];
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/store_issue.sv
// Store alignment, buffering and bus drain. Define
// STORE_HAZARD_CHECK_EN for word-exact load hazard compare.
module store_issue
    import store_issue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    input  logic [31:0]       st_addr,
    input  logic [31:0]       st_data,
    input  logic [1:0]        st_size,
    output logic              st_ready,
    output logic              st_ades,
    input  logic [31:0]       load_addr,
    input  logic              load_valid,
    output logic              load_conflict,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [31:0]       data_addr,
    output logic [31:0]       data_wdata,
    output logic [3:0]        data_wstrb,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    output logic [CNT_W-1:0]  sb_count,
    output logic              sb_empty
);

    logic [1:0]        off;
    logic              misalign;
    logic [STRB_W-1:0] al_wstrb;
    logic [DATA_W-1:0] al_wdata;

    assign off = st_addr[1:0];

    always_comb begin
        misalign = 1'b0;
        al_wstrb = '0;
        al_wdata = '0;
        unique case (st_size)
            SIZE_BYTE: begin
                al_wstrb = 4'b0001 << off;
                al_wdata = {4{st_data[7:0]}};
            end
            SIZE_HALF: begin
                misalign = off[0];
                al_wstrb = off[1] ? 4'b1100 : 4'b0011;
                al_wdata = {2{st_data[15:0]}};
            end
            SIZE_WORD: begin
                misalign = |off;
                al_wstrb = 4'b1111;
                al_wdata = st_data;
            end
            default: misalign = 1'b1;
        endcase
    end

    assign st_ades  = st_valid & misalign;
    assign st_ready = sb_count != CNT_W'(DEPTH);

    logic      enq;
    logic      pop;
    sb_entry_t new_ent;
    sb_entry_t head;

    assign enq           = st_valid & st_ready & ~st_ades;
    assign new_ent.addr  = st_addr;
    assign new_ent.size  = st_size;
    assign new_ent.wdata = al_wdata;
    assign new_ent.wstrb = al_wstrb;

    logic [DEPTH-1:0]             ent_valid;
    logic [DEPTH-1:0][WORD_W-1:0] ent_word;

    store_buffer_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (enq),
        .push_entry_i (new_ent),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (sb_count),
        .ent_valid_o  (ent_valid),
        .ent_word_o   (ent_word)
    );

    assign sb_empty = sb_count == '0;

    sb_state_e        state_q;
    logic             req_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic             more;

    assign pop = (state_q == ST_REQ  & data_addr_ok & data_data_ok)
               | (state_q == ST_WAIT & data_data_ok);

    // Occupancy after this edge, counting a same-cycle enqueue.
    assign cnt_nxt = sb_count - CNT_W'(1) + CNT_W'(enq);
    assign more    = cnt_nxt != '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!sb_empty) begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (data_addr_ok && data_data_ok) begin
                        state_q <= more ? ST_REQ : ST_IDLE;
                        req_q   <= more;
                    end else if (data_addr_ok) begin
                        state_q <= ST_WAIT;
                        req_q   <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (data_data_ok) begin
                        state_q <= more ? ST_REQ : ST_IDLE;
                        req_q   <= more;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign data_req   = req_q;
    assign data_wr    = req_q;
    assign data_size  = req_q ? head.size  : '0;
    assign data_addr  = req_q ? head.addr  : '0;
    assign data_wdata = req_q ? head.wdata : '0;
    assign data_wstrb = req_q ? head.wstrb : '0;

`ifdef STORE_HAZARD_CHECK_EN
    logic hit;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit = hit | word_hit(ent_valid[i], ent_word[i],
                                 load_addr[ADDR_W-1:2]);
        end
    end

    assign load_conflict = load_valid & hit;

    logic unused_ok;
    assign unused_ok = &{1'b0, load_addr[1:0]};
`else
    // Conservative: any buffered store blocks the load.
    assign load_conflict = load_valid & ~sb_empty;

    logic unused_ok;
    assign unused_ok = &{1'b0, ent_valid, ent_word, load_addr};
`endif

endmodule

// File: tb/tb_store_issue.sv
// Randomised bench for store_issue against a queue-based model
// of the store buffer and the bus drain protocol.
module tb_store_issue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [1:0]  st_size = '0;
    logic        st_ready;
    logic        st_ades;
    logic [31:0] load_addr = '0;
    logic        load_valid = 1'b0;
    logic        load_conflict;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [CNT_W-1:0] sb_count;
    logic        sb_empty;

    store_issue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .st_valid      (st_valid),
        .st_addr       (st_addr),
        .st_data       (st_data),
        .st_size       (st_size),
        .st_ready      (st_ready),
        .st_ades       (st_ades),
        .load_addr     (load_addr),
        .load_valid    (load_valid),
        .load_conflict (load_conflict),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_size     (data_size),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_wstrb    (data_wstrb),
        .data_addr_ok  (data_addr_ok),
        .data_data_ok  (data_data_ok),
        .sb_count      (sb_count),
        .sb_empty      (sb_empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    bit   outstanding = 0;
    int   idle_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_bad(input logic [31:0] a, input logic [1:0] s);
        if (s == 2'd3) return 1;
        if (s == 2'd1) return a % 2 != 0;
        if (s == 2'd2) return a % 4 != 0;
        return 0;
    endfunction

    function automatic exp_t m_ent(input logic [31:0] a, input logic [31:0] d,
                                   input logic [1:0] s);
        exp_t e;
        e.addr = a;
        e.size = s;
        if (s == 2'd0) begin
            e.wstrb = 4'(1 << (a % 4));
            e.wdata = (d & 32'hFF) * 32'h0101_0101;
        end else if (s == 2'd1) begin
            e.wstrb = ((a / 2) % 2 == 1) ? 4'hC : 4'h3;
            e.wdata = (d & 32'hFFFF) * 32'h0001_0001;
        end else begin
            e.wstrb = 4'hF;
            e.wdata = d;
        end
        return e;
    endfunction

    function automatic bit m_conflict(input bit lv, input logic [31:0] la);
        if (!lv) return 0;
`ifdef STORE_HAZARD_CHECK_EN
        foreach (q[i]) if (q[i].addr / 4 == la / 4) return 1;
        return 0;
`else
        return q.size() != 0;
`endif
    endfunction

    task automatic cycle(input bit sv, input logic [31:0] sa,
                         input logic [31:0] sd, input logic [1:0] ss,
                         input bit lv, input logic [31:0] la,
                         input bit aok, input bit dok, output bit acc);
        bit ades;
        bit pop;
        @(negedge clk);
        st_valid     = sv;
        st_addr      = sa;
        st_data      = sd;
        st_size      = ss;
        load_valid   = lv;
        load_addr    = la;
        data_addr_ok = aok;
        data_data_ok = dok;
        #1;
        ades = sv && m_bad(sa, ss);
        chk("sb_count", sb_count, q.size());
        chk("sb_empty", sb_empty, q.size() == 0);
        chk("st_ready", st_ready, q.size() != DEPTH);
        chk("st_ades", st_ades, ades);
        chk("load_conflict", load_conflict, m_conflict(lv, la));
        chk("data_wr", data_wr, data_req);
        if (data_req) begin
            chk("req_outstanding", outstanding, 0);
            chk("req_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
                chk("bus_addr", data_addr, q[0].addr);
                chk("bus_size", data_size, q[0].size);
                chk("bus_wdata", data_wdata, q[0].wdata);
                chk("bus_wstrb", data_wstrb, q[0].wstrb);
            end
        end else begin
            chk("idle_bus", {data_addr | data_wdata}, 0);
            chk("idle_ctl", {data_size, data_wstrb}, 0);
        end
        if (q.size() != 0 && !outstanding && !data_req) idle_cnt++;
        else idle_cnt = 0;
        chk("req_latency", idle_cnt > 1, 0);
        acc = sv && !ades && q.size() != DEPTH;
        pop = (data_req && aok && dok) || (outstanding && dok);
        if (outstanding && dok) outstanding = 0;
        else if (data_req && aok && !dok) outstanding = 1;
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(m_ent(sa, sd, ss));
    endtask

    task automatic idle(input bit aok, input bit dok);
        bit acc;
        cycle(0, 0, 0, 0, 0, 0, aok, dok, acc);
    endtask

    initial begin
        bit acc;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_count", sb_count, 0);
        chk("rst_empty", sb_empty, 1);
        chk("rst_ready", st_ready, 1);
        chk("rst_req", {data_req, data_wr}, 0);
        chk("rst_bus", data_addr | data_wdata, 0);
        @(negedge clk);
        rst = 1'b0;

        // Byte store with a one-cycle bus ack
        cycle(1, 32'h1003, 32'h0000_00AB, 2'd0, 0, 0, 0, 0, acc);
        idle(0, 0);
        idle(0, 0);
        chk("byte_req", data_req, 1);
        chk("byte_addr", data_addr, 32'h1003);
        chk("byte_wstrb", data_wstrb, 4'b1000);
        chk("byte_wdata", data_wdata, 32'hABAB_ABAB);
        idle(1, 1);
        idle(0, 0);
        chk("byte_empty", sb_empty, 1);

        // Misaligned and illegal stores are dropped
        cycle(1, 32'h2001, 32'h1234, 2'd1, 0, 0, 0, 0, acc);
        chk("ades_half", st_ades, 1);
        cycle(1, 32'h2002, 32'h1234, 2'd2, 0, 0, 0, 0, acc);
        chk("ades_word", st_ades, 1);
        cycle(1, 32'h2000, 32'h1234, 2'd3, 0, 0, 0, 0, acc);
        chk("ades_size", st_ades, 1);
        idle(0, 0);
        chk("ades_count", sb_count, 0);

        // Fill past capacity, then drain with combined acks
        for (int i = 0; i < 5; i++) begin
            int  tries = 0;
            bit  ack;
            acc = 0;
            while (!acc && tries < 20) begin
                ack = (i == 4) && (tries >= 3);
                cycle(1, 32'h4000 + 4 * i, 32'h1111_0000 + i, 2'd2, 0, 0,
                      ack, ack, acc);
                tries++;
            end
            chk("fill_accept", acc, 1);
        end
        repeat (12) idle(1, 1);
        chk("fill_drained", sb_empty, 1);

        // Hazard compare at word granularity
        cycle(1, 32'h3004, 32'hCAFE_F00D, 2'd2, 0, 0, 0, 0, acc);
        cycle(0, 0, 0, 0, 1, 32'h3006, 0, 0, acc);
        cycle(0, 0, 0, 0, 1, 32'h3008, 0, 0, acc);
        repeat (6) idle(1, 1);

        // Asynchronous reset while waiting on data_ok
        for (int i = 0; i < 3; i++)
            cycle(1, 32'h6000 + 4 * i, 32'h2222_0000 + i, 2'd2, 0, 0, 0, 0, acc);
        idle(1, 0);
        st_valid     = 0;
        data_addr_ok = 0;
        data_data_ok = 0;
        @(posedge clk);
        #2;
        chk("pre_rst_count", sb_count, q.size());
        rst = 1'b1;
        #1;
        chk("mid_rst_req", data_req, 0);
        chk("mid_rst_count", sb_count, 0);
        q.delete();
        outstanding = 0;
        idle_cnt    = 0;
        @(negedge clk);
        rst = 1'b0;
        cycle(1, 32'h7002, 32'h0000_BEEF, 2'd1, 0, 0, 0, 0, acc);
        repeat (4) idle(1, 1);
        chk("post_rst_empty", sb_empty, 1);

        // Randomised traffic with independent bus acks
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom % 3 != 0,
                  32'h5000 + $urandom_range(0, 15),
                  $urandom,
                  2'($urandom_range(0, 3)),
                  $urandom % 2 == 1,
                  32'h5000 + $urandom_range(0, 15),
                  $urandom % 2 == 1,
                  $urandom % 2 == 1,
                  acc);
        end
        repeat (20) idle(1, 1);
        chk("final_empty", sb_empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
